mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory-stage access controller sitting on the output side of the EX/MEM pipeline register. It consumes the registered memory controls (memen, MemRead, MemWrite, createdump, HaltRaw), drives the multi-cycle data memory through a Rd/Wr/Stall/Done handshake, and holds the pipeline while an access is outstanding. It back-drives the EX/MEM `w_en`, hands MEM/WB a valid flag and read data, and latches processor halt.

## Interface
- W, 16, data/address width
- TIMEOUT, 64, max cycles in WAIT before a watchdog error (used only with MEM_TIMEOUT_EN)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- memen_i, MemRead_i, MemWrite_i  in  1 each  registered EX/MEM memory controls
- createdump_i, HaltRaw_i  in  1 each  registered EX/MEM dump/halt controls
- addr_i  in  W  access address (EX/MEM ex_result)
- wdata_i  in  W  store data (EX/MEM WriteData)
- mem_Rd, mem_Wr  out  1 each  read/write request to data memory
- mem_Addr, mem_DataIn  out  W each  request address/data (addr_i, wdata_i pass-through)
- mem_createdump  out  1  one-cycle dump pulse
- mem_DataOut  in  W  memory read data, valid with mem_Done
- mem_Done  in  1  access complete this cycle
- mem_Stall  in  1  memory busy, request not accepted
- exmem_wen  out  1  drives EX/MEM `w_en`; 0 holds EX/MEM
- memwb_valid  out  1  instruction leaves MEM this cycle (0 = bubble into MEM/WB)
- readData_o  out  W  load data to MEM/WB
- halt_o  out  1  sticky processor halt
- err  out  1  sticky error, OR-reduced into the processor err like other blocks

## Operation
- access = memen_i & (MemRead_i | MemWrite_i). States: IDLE, WAIT, HALTED.
- IDLE, no access, HaltRaw_i=0: exmem_wen=1, memwb_valid=1.
- IDLE, access: mem_Rd=MemRead_i and mem_Wr=MemWrite_i asserted combinationally.
  - mem_Stall=1: request not accepted, stay IDLE, exmem_wen=0, memwb_valid=0, retry next cycle.
  - mem_Stall=0, mem_Done=1 (hit): complete, exmem_wen=1, memwb_valid=1.
  - mem_Stall=0, mem_Done=0: accepted, go WAIT, exmem_wen=0, memwb_valid=0.
- WAIT: mem_Rd=mem_Wr=0, exmem_wen=0, memwb_valid=0 until mem_Done=1. In the Done cycle: exmem_wen=1, memwb_valid=1, go IDLE.
- readData_o = mem_Done ? mem_DataOut : rdata_q. rdata_q loads mem_DataOut on every Done, so MEM/WB captures it at the same edge.
- Halt: IDLE with HaltRaw_i=1 and no access. mem_createdump=createdump_i for that one cycle, memwb_valid=1, go HALTED, halt_o=1 from next cycle. HALTED: exmem_wen=0, memwb_valid=0, no requests; exits only on rst.
- err sets (sticky until rst) on any of:
  - access with addr_i[0]=1 (unaligned); request is still issued
  - memen_i & MemRead_i & MemWrite_i; neither request is issued and the access completes as if it were a hit
  - watchdog expiry (see Configuration)
- mem_Done in IDLE without a request is ignored, except that it updates rdata_q.

## Timing
- rst asserted: state←IDLE, rdata_q←0, wait counter←0, err←0, halt_o←0. While rst=1: mem_Rd=mem_Wr=mem_createdump=0, exmem_wen=1 (pipeline registers reset normally), memwb_valid=0.
- Reset in WAIT returns to IDLE on the next edge. Any in-flight memory response is dropped.
- Latency: a hit completes in 1 cycle (0 stall cycles). A miss with Done N cycles after acceptance holds EX/MEM for N cycles. A refused request adds 1 cycle per mem_Stall cycle.
- Rd/Wr are asserted only in IDLE, for exactly the acceptance cycle (plus retries). There is never more than one outstanding request.
- Simultaneous HaltRaw_i and access in the same cycle: the access is serviced first, and halt takes effect on the cycle the access completes.

## Configuration
- MEM_TIMEOUT_EN defined: a log2(TIMEOUT)-bit counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT-1 without Done: err←1, exmem_wen=1, memwb_valid=1 (load returns rdata_q), go IDLE.
- Undefined: no counter, WAIT is unbounded, and err comes only from unaligned/conflict conditions.

## Test plan
- Load hit: memen=1, MemRead=1, addr=0x0010, Stall=0, Done=1, DataOut=0xBEEF same cycle -> mem_Rd=1 one cycle, exmem_wen=1, memwb_valid=1, readData_o=0xBEEF, no stall.
- Load miss: Done 3 cycles after acceptance with DataOut=0x1234 -> exmem_wen=0 for 3 cycles, then 1 with memwb_valid=1 and readData_o=0x1234; mem_Rd high only in the acceptance cycle.
- Store with refusal: MemWrite=1, wdata=0xA5A5, Stall=1 for 2 cycles then accepted with Done=1 -> mem_Wr high 3 cycles, mem_DataIn=0xA5A5, exmem_wen=0,0,1.
- Halt: HaltRaw=1, createdump=1, no access -> mem_createdump pulses once, halt_o=1 next cycle and stays, exmem_wen=0 until rst.
- Errors: load at addr 0x0011 -> err=1 and sticky, load still completes. MemRead=MemWrite=1 -> err=1, no Rd/Wr. MEM_TIMEOUT_EN with TIMEOUT=8 and Done never asserted -> err=1 after 8 WAIT cycles, return to IDLE.
- Reset mid-WAIT: rst=1 on the 2nd WAIT cycle -> next cycle IDLE, err=0, readData_o=0, exmem_wen=1. A late Done is ignored apart from updating rdata_q.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Memory-stage access controller on the output side of the EX/MEM register.
//   It issues read/write requests to a multi-cycle data memory using a
//   Rd/Wr/Stall/Done handshake. While an access is outstanding it holds the
//   pipeline through exmem_wen. It also hands MEM/WB a valid flag and the load
//   data, and it latches the processor halt.
//
//   Optional feature macro: MEM_TIMEOUT_EN. When it is defined, a watchdog
//   counter bounds the time spent in WAIT to TIMEOUT cycles.
//
// Parameters
//   W        data/address width
//   TIMEOUT  WAIT-cycle bound for the watchdog (MEM_TIMEOUT_EN only)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   memen_i, MemRead_i,
//   MemWrite_i               registered EX/MEM memory controls
//   createdump_i, HaltRaw_i  registered EX/MEM dump/halt controls
//   addr_i, wdata_i          access address / store data
//   mem_Rd, mem_Wr           request strobes to data memory
//   mem_Addr, mem_DataIn     request address / data (pass-through)
//   mem_createdump           one-cycle dump pulse
//   mem_DataOut, mem_Done,
//   mem_Stall                memory response / completion / busy
//   exmem_wen                EX/MEM write enable (0 holds EX/MEM)
//   memwb_valid              instruction leaves MEM this cycle
//   readData_o               load data to MEM/WB
//   halt_o                   sticky processor halt
//   err                      sticky error flag
module mem_access_ctrl #(
   parameter int W       = 16,
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         memen_i,
   input  logic         MemRead_i,
   input  logic         MemWrite_i,
   input  logic         createdump_i,
   input  logic         HaltRaw_i,
   input  logic [W-1:0] addr_i,
   input  logic [W-1:0] wdata_i,
   output logic         mem_Rd,
   output logic         mem_Wr,
   output logic [W-1:0] mem_Addr,
   output logic [W-1:0] mem_DataIn,
   output logic         mem_createdump,
   input  logic [W-1:0] mem_DataOut,
   input  logic         mem_Done,
   input  logic         mem_Stall,
   output logic         exmem_wen,
   output logic         memwb_valid,
   output logic [W-1:0] readData_o,
   output logic         halt_o,
   output logic         err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [W-1:0]   rdata_q;
   logic           err_q;
   logic           halt_q;
   logic           err_set;
   logic           complete;
   logic           wd_expire;

   logic access;
   logic conflict;
   logic unaligned;

   assign access    = memen_i & (MemRead_i | MemWrite_i);
   assign conflict  = memen_i & MemRead_i & MemWrite_i;
   assign unaligned = access & addr_i[0];

   assign mem_Addr   = addr_i;
   assign mem_DataIn = wdata_i;
   // Load data is forwarded in the Done cycle, so MEM/WB captures it at the same edge as rdata_q.
   assign readData_o = mem_Done ? mem_DataOut : rdata_q;
   assign halt_o     = halt_q;
   assign err        = err_q;

`ifdef MEM_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   logic [CW-1:0] wait_cnt;

   assign wd_expire = (state == WAIT) && (wait_cnt == CW'(TIMEOUT - 1));

   // Watchdog: held at zero outside WAIT so it starts from zero on every WAIT entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= {CW{1'b0}};
      end else if (state != WAIT) begin
         wait_cnt <= {CW{1'b0}};
      end else begin
         wait_cnt <= wait_cnt + CW'(1);
      end
   end
`else
   // Without the watchdog, WAIT is unbounded. TIMEOUT only sets the compile-time constant here.
   assign wd_expire = (TIMEOUT < 0);
`endif

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt      = state;
      mem_Rd         = 1'b0;
      mem_Wr         = 1'b0;
      mem_createdump = 1'b0;
      exmem_wen      = 1'b0;
      memwb_valid    = 1'b0;
      err_set        = 1'b0;
      complete       = 1'b0;
      if (rst) begin
         // While reset is asserted, the pipeline registers still reset normally.
         exmem_wen = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (access) begin
                  err_set = unaligned | conflict;
                  if (conflict) begin
                     // A conflicting read+write issues no request and retires like a hit.
                     complete = 1'b1;
                  end else begin
                     mem_Rd = MemRead_i;
                     mem_Wr = MemWrite_i;
                     if (mem_Stall) begin
                        complete = 1'b0;
                     end else if (mem_Done) begin
                        complete = 1'b1;
                     end else begin
                        state_nxt = WAIT;
                     end
                  end
               end else if (HaltRaw_i) begin
                  complete = 1'b1;
               end else begin
                  exmem_wen   = 1'b1;
                  memwb_valid = 1'b1;
               end
            end
            WAIT: begin
               if (mem_Done) begin
                  complete = 1'b1;
               end else if (wd_expire) begin
                  complete = 1'b1;
                  err_set  = 1'b1;
               end else begin
                  complete = 1'b0;
               end
            end
            HALTED: begin
               state_nxt = HALTED;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase

         // A pending halt takes effect in the cycle the instruction retires, which may be after an access.
         if (complete) begin
            exmem_wen   = 1'b1;
            memwb_valid = 1'b1;
            if (HaltRaw_i) begin
               state_nxt      = HALTED;
               mem_createdump = createdump_i;
            end else begin
               state_nxt = IDLE;
            end
         end else begin
            mem_createdump = 1'b0;
         end
      end
   end

   // State, read-data holding register, and sticky flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rdata_q <= {W{1'b0}};
         err_q   <= 1'b0;
         halt_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (mem_Done) begin
            rdata_q <= mem_DataOut;
         end
         err_q  <= err_q | err_set;
         halt_q <= halt_q | (state_nxt == HALTED);
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        memen, rd, wr, cd, halt;
   logic [15:0] addr, wdata, dout;
   logic        done, stall;
   logic        mem_Rd, mem_Wr, mem_createdump, exmem_wen, memwb_valid, halt_o, err;
   logic [15:0] mem_Addr, mem_DataIn, readData_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.W(16), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .memen_i(memen), .MemRead_i(rd), .MemWrite_i(wr),
      .createdump_i(cd), .HaltRaw_i(halt),
      .addr_i(addr), .wdata_i(wdata),
      .mem_Rd(mem_Rd), .mem_Wr(mem_Wr), .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn),
      .mem_createdump(mem_createdump), .mem_DataOut(dout), .mem_Done(done), .mem_Stall(stall),
      .exmem_wen(exmem_wen), .memwb_valid(memwb_valid), .readData_o(readData_o),
      .halt_o(halt_o), .err(err)
   );

   typedef struct {
      logic        memen, rd, wr;
      logic [15:0] addr, wdata;
      logic        done, stall;
      logic [15:0] dout;
      logic        e_rd, e_wr, e_wen, e_val;
      logic [15:0] e_rdata;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic m, input logic r, input logic w, input logic h, input logic c,
                        input logic [15:0] a, input logic [15:0] wd, input logic dn,
                        input logic st, input logic [15:0] d);
      memen = m; rd = r; wr = w; halt = h; cd = c;
      addr = a; wdata = wd; done = dn; stall = st; dout = d;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      //              memen rd wr addr      wdata     done stall dout     rd wr wen val rdata
      tbl[0]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b1,1'b1,16'h0000};
      tbl[1]  = '{1'b1,1'b1,1'b0,16'h0010,16'h0000,1'b1,1'b0,16'hBEEF, 1'b1,1'b0,1'b1,1'b1,16'hBEEF};
      tbl[2]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h1111, 1'b0,1'b0,1'b1,1'b1,16'hBEEF};
      tbl[3]  = '{1'b1,1'b0,1'b1,16'h0020,16'h5555,1'b1,1'b0,16'h0000, 1'b0,1'b1,1'b1,1'b1,16'h0000};
      tbl[4]  = '{1'b0,1'b1,1'b0,16'h0030,16'h0000,1'b0,1'b0,16'h2222, 1'b0,1'b0,1'b1,1'b1,16'h0000};
      tbl[5]  = '{1'b1,1'b1,1'b0,16'h0030,16'h0000,1'b0,1'b1,16'h2222, 1'b1,1'b0,1'b0,1'b0,16'h0000};
      tbl[6]  = '{1'b1,1'b1,1'b0,16'h0030,16'h0000,1'b0,1'b0,16'h2222, 1'b1,1'b0,1'b0,1'b0,16'h0000};
      tbl[7]  = '{1'b1,1'b1,1'b0,16'h0030,16'h0000,1'b0,1'b0,16'h2222, 1'b0,1'b0,1'b0,1'b0,16'h0000};
      tbl[8]  = '{1'b1,1'b1,1'b0,16'h0030,16'h0000,1'b1,1'b0,16'h7777, 1'b0,1'b0,1'b1,1'b1,16'h7777};
      tbl[9]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,16'h3333, 1'b0,1'b0,1'b1,1'b1,16'h3333};
      tbl[10] = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h4444, 1'b0,1'b0,1'b1,1'b1,16'h3333};
      tbl[11] = '{1'b1,1'b0,1'b0,16'h0040,16'h0000,1'b0,1'b0,16'h4444, 1'b0,1'b0,1'b1,1'b1,16'h3333};

      // Reset values
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000);
      smp();
      chk("rst_rd", mem_Rd, 1'b0);
      chk("rst_wen", exmem_wen, 1'b1);
      chk("rst_val", memwb_valid, 1'b0);
      chk("rst_dump", mem_createdump, 1'b0);
      cyc();
      do_reset();
      smp();
      chk("post_rst_rdata", readData_o, 16'h0000);
      chk("post_rst_err", err, 1'b0);
      chk("post_rst_halt", halt_o, 1'b0);
      cyc();

      // Table-driven single-cycle vectors
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].memen, tbl[i].rd, tbl[i].wr, 1'b0, 1'b0, tbl[i].addr, tbl[i].wdata,
               tbl[i].done, tbl[i].stall, tbl[i].dout);
         smp();
         chk($sformatf("v%0d_rd", i), mem_Rd, tbl[i].e_rd);
         chk($sformatf("v%0d_wr", i), mem_Wr, tbl[i].e_wr);
         chk($sformatf("v%0d_wen", i), exmem_wen, tbl[i].e_wen);
         chk($sformatf("v%0d_val", i), memwb_valid, tbl[i].e_val);
         chk($sformatf("v%0d_rdata", i), readData_o, tbl[i].e_rdata);
         chk($sformatf("v%0d_addr", i), mem_Addr, tbl[i].addr);
         chk($sformatf("v%0d_err", i), err, 1'b0);
         cyc();
      end

      // Load miss: Done three cycles after acceptance
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000);
      smp(); chk("miss_acc_rd", mem_Rd, 1'b1); chk("miss_acc_wen", exmem_wen, 1'b0);
      cyc();
      for (int k = 0; k < 2; k++) begin
         smp(); chk("miss_wait_rd", mem_Rd, 1'b0); chk("miss_wait_wen", exmem_wen, 1'b0);
         chk("miss_wait_val", memwb_valid, 1'b0);
         cyc();
      end
      done = 1'b1; dout = 16'h1234;
      smp(); chk("miss_done_wen", exmem_wen, 1'b1); chk("miss_done_val", memwb_valid, 1'b1);
      chk("miss_done_rdata", readData_o, 16'h1234); chk("miss_done_rd", mem_Rd, 1'b0);
      cyc();

      // Store refused twice then accepted as a hit
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0040, 16'hA5A5, (k == 2), (k != 2), 16'h0000);
         smp();
         chk("st_wr", mem_Wr, 1'b1);
         chk("st_din", mem_DataIn, 16'hA5A5);
         chk("st_wen", exmem_wen, (k == 2) ? 1'b1 : 1'b0);
         cyc();
      end

      // Unaligned load still completes, err is sticky
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, 1'b1, 1'b0, 16'h4242);
      smp(); chk("ua_rd", mem_Rd, 1'b1); chk("ua_wen", exmem_wen, 1'b1);
      chk("ua_rdata", readData_o, 16'h4242); chk("ua_err_lat", err, 1'b0);
      cyc();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
      smp(); chk("ua_err", err, 1'b1); cyc();
      smp(); chk("ua_err_sticky", err, 1'b1); cyc();

      // Reset on the second WAIT cycle, then a late Done
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h0000);
      smp(); chk("rw_acc_rd", mem_Rd, 1'b1); cyc();
      smp(); chk("rw_wait_wen", exmem_wen, 1'b0); cyc();
      rst = 1'b1;
      smp(); chk("rw_rst_rd", mem_Rd, 1'b0); chk("rw_rst_wen", exmem_wen, 1'b1);
      chk("rw_rst_val", memwb_valid, 1'b0);
      cyc();
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
      smp(); chk("rw_idle_wen", exmem_wen, 1'b1); chk("rw_idle_val", memwb_valid, 1'b1);
      chk("rw_rdata0", readData_o, 16'h0000); chk("rw_err0", err, 1'b0);
      cyc();
      done = 1'b1; dout = 16'h9999;
      smp(); chk("late_rdata", readData_o, 16'h9999); chk("late_rd", mem_Rd, 1'b0);
      chk("late_wen", exmem_wen, 1'b1);
      cyc();
      done = 1'b0; dout = 16'h0000;
      smp(); chk("late_rdata_q", readData_o, 16'h9999); cyc();

      // Read+write conflict: no request, retires, err set
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0050, 16'h0000, 1'b0, 1'b0, 16'h0000);
      smp(); chk("cf_rd", mem_Rd, 1'b0); chk("cf_wr", mem_Wr, 1'b0);
      chk("cf_wen", exmem_wen, 1'b1); chk("cf_val", memwb_valid, 1'b1);
      cyc();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
      smp(); chk("cf_err", err, 1'b1); cyc();
      do_reset();

      // Halt arriving with an access: the access is serviced first
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0030, 16'h0000, 1'b0, 1'b0, 16'h0000);
      smp(); chk("ha_acc_dump", mem_createdump, 1'b0); chk("ha_acc_rd", mem_Rd, 1'b1);
      chk("ha_acc_wen", exmem_wen, 1'b0);
      cyc();
      done = 1'b1; dout = 16'h0BAD;
      smp(); chk("ha_done_val", memwb_valid, 1'b1); chk("ha_done_dump", mem_createdump, 1'b1);
      chk("ha_done_halt", halt_o, 1'b0);
      cyc();
      done = 1'b0;
      smp(); chk("ha_halt", halt_o, 1'b1); chk("ha_wen", exmem_wen, 1'b0); cyc();
      do_reset();

      // Plain halt with dump
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
      smp(); chk("h_dump", mem_createdump, 1'b1); chk("h_val", memwb_valid, 1'b1);
      chk("h_halt_lat", halt_o, 1'b0);
      cyc();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0000);
      for (int k = 0; k < 3; k++) begin
         smp();
         chk("hd_halt", halt_o, 1'b1); chk("hd_dump", mem_createdump, 1'b0);
         chk("hd_wen", exmem_wen, 1'b0); chk("hd_val", memwb_valid, 1'b0);
         chk("hd_rd", mem_Rd, 1'b0);
         cyc();
      end
      rst = 1'b1;
      smp(); chk("hr_wen", exmem_wen, 1'b1); chk("hr_val", memwb_valid, 1'b0); cyc();
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
      smp(); chk("hr_halt0", halt_o, 1'b0); chk("hr_wen1", exmem_wen, 1'b1); cyc();

      // Never-answered miss: watchdog when enabled, unbounded wait otherwise
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0060, 16'h0000, 1'b0, 1'b0, 16'h0000);
      smp(); chk("to_acc_rd", mem_Rd, 1'b1); cyc();
`ifdef MEM_TIMEOUT_EN
      for (int k = 1; k <= 8; k++) begin
         smp();
         chk("to_wen", exmem_wen, (k == 8) ? 1'b1 : 1'b0);
         chk("to_val", memwb_valid, (k == 8) ? 1'b1 : 1'b0);
         chk("to_err_lat", err, 1'b0);
         cyc();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
      smp(); chk("to_err", err, 1'b1); chk("to_idle_wen", exmem_wen, 1'b1); cyc();
`else
      for (int k = 1; k <= 20; k++) begin
         smp(); chk("nt_wen", exmem_wen, 1'b0); chk("nt_err", err, 1'b0); cyc();
      end
      done = 1'b1; dout = 16'h00AA;
      smp(); chk("nt_done_wen", exmem_wen, 1'b1); chk("nt_done_rdata", readData_o, 16'h00AA);
      cyc();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
